// File: rtl/cdc_rx_fifo.sv
// cdc_rx_fifo
// Destination-side receive buffer behind a CDC handshake. Valid pulses from
// the crossing carry no backpressure. Each word is stored in a small
// synchronous FIFO and offered again as a first-word-fall-through
// valid/ready stream. A word that arrives while the FIFO is full is dropped
// and sets a sticky overflow flag.
//
// Ports:
//   clk_i        destination-domain clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   word present this cycle (pulse, no ready)
//   in_data_i    incoming word
//   out_valid_o  head word available
//   out_ready_i  consumer takes the head word
//   out_data_o   head word (FWFT; don't-care while empty)
//   level_o      number of stored words, 0..Depth
//   overflow_o   sticky: a word was dropped
//   ovf_clear_i  clears overflow_o (a drop in the same cycle wins)
module cdc_rx_fifo #(
  parameter int unsigned Bits  = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [Bits-1:0]          in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [Bits-1:0]          out_data_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     overflow_o,
  input  logic                     ovf_clear_i
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(Depth);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [Bits-1:0] mem_q [Depth];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;

  logic [AW:0]     level;
  logic            full, empty, pop, push, drop;

  // Pointers carry one extra wrap bit, so a plain modulo subtraction gives
  // the fill level from 0 to Depth.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  assign pop  = !empty && out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = in_valid_i && (!full || pop);
  assign drop = in_valid_i && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)             ovf_d = 1'b1;
    else if (ovf_clear_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
  end

  assign out_valid_o = !empty;
  assign out_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o     = level;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cdc_rx_fifo.sv
module tb_cdc_rx_fifo;

  localparam int D = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid_i = 1'b0;
  logic [7:0] in_data_i = '0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] out_data_o;
  logic [2:0] level_o;
  logic       overflow_o;
  logic       ovf_clear_i = 1'b0;

  cdc_rx_fifo #(.Bits(8), .Depth(D)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .ovf_clear_i (ovf_clear_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Scoreboard: words accepted by the model wait here until popped.
  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;
  logic [7:0] last_pop = '0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    int         exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the DUT against the scoreboard model; called at a falling edge.
  task automatic sb_check();
    chk("sb_valid", 32'(out_valid_o), 32'(sb.size() != 0));
    chk("sb_level", 32'(level_o), 32'(sb.size()));
    chk("sb_ovf", 32'(overflow_o), 32'(m_ovf));
    if (sb.size() != 0) chk("sb_data", 32'(out_data_o), 32'(sb[0]));
  endtask

  // Drives one cycle from a falling edge and updates the model at the
  // rising edge; returns at the next falling edge after checking.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    logic pop, push, drop;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = rdy;
    ovf_clear_i = clr;
    @(posedge clk_i);
    pop  = (sb.size() != 0) && rdy;
    push = v && ((sb.size() < D) || pop);
    drop = v && !push;
    if (pop) last_pop = sb.pop_front();
    if (push) sb.push_back(d);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    ovf_clear_i = 1'b0;
    sb_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 1'b0};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 1'b0};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 1'b0};
    vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single push appears after the edge
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_valid", 32'(out_valid_o), 32'd1);
    chk("a5_data", 32'(out_data_o), 32'hA5);
    chk("a5_level", 32'(level_o), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_popped", 32'(last_pop), 32'hA5);

    // Fill, overflow, drain, clear
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_level", i), 32'(level_o), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].exp_ovf));
      if (i >= 5 && i <= 8)
        chk($sformatf("vec%0d_pop", i), 32'(last_pop), 32'(i - 4));
    end
    chk("drain_valid", 32'(out_valid_o), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < D; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    step(1'b1, 8'h10, 1'b1, 1'b0);
    chk("fpp_level", 32'(level_o), 32'd4);
    chk("fpp_ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fpp_last", 32'(last_pop), 32'h10);
    chk("fpp_empty", 32'(level_o), 32'd0);

    // Empty with push and ready: push only
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("epr_level", 32'(level_o), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming with ready held high; pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      chk("stream_level_le1", 32'(level_o <= 3'd1), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_last", 32'(last_pop), 32'h53);
    chk("stream_ovf", 32'(overflow_o), 32'd0);

    // Drop and clear in the same cycle: set wins
    for (int i = 0; i < D; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("setwins_ovf", 32'(overflow_o), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clear_ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with three words stored
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level_o), 32'd3);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_level", 32'(level_o), 32'd0);
    sb.delete();
    m_ovf = 1'b0;
    @(negedge clk_i);
    chk("in_rst_valid", 32'(out_valid_o), 32'd0);
    rst_ni = 1'b1;
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_pop1", 32'(last_pop), 32'hC1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_pop2", 32'(last_pop), 32'hC2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
